// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle glue controller: decodes addr[23:20] into ROM/RAM/IO,
// drives registered chip selects and RAM byte strobes, inserts per-region
// wait states and ends each cycle with DTACK_n, or with BERR_n on timeout.
module bus_cycle_ctrl #(
    parameter int unsigned ROM_WAIT     = 2,
    parameter int unsigned RAM_WAIT     = 0,
    parameter int unsigned IO_WAIT      = 3,
    parameter int unsigned BERR_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        read,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic [23:0] addr,
    input  logic        io_ready,
    output logic        dtack_n,
    output logic        berr_n,
    output logic        rom_cs_n,
    output logic        ram_cs_n,
    output logic        io_cs_n,
    output logic        ram_we_hi_n,
    output logic        ram_we_lo_n,
    output logic        data_oe_n,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_ACK     = 3'd2,
        S_BERR    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_ROM  = 2'd1,
        R_RAM  = 2'd2,
        R_IO   = 2'd3
    } region_t;

    localparam logic [7:0] TMO_LAST = 8'(BERR_TIMEOUT - 1);

    state_t      cur_state, nxt_state;
    region_t     decoded, region_q, region_d;
    logic        read_q, read_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        in_cycle, strobes_valid;
    logic        dtack_d, berr_d, rom_cs_d, ram_cs_d, io_cs_d;
    logic        we_hi_d, we_lo_d, oe_d;

    // Low address bits are decoded by the devices themselves.
    logic        addr_unused;
    assign addr_unused = ^addr[19:0];

    assign state = cur_state;

    // Region decode of the live address.
    always_comb begin
        case (addr[23:20])
            4'h0:    decoded = R_ROM;
            4'h1:    decoded = R_RAM;
            4'hF:    decoded = R_IO;
            default: decoded = R_NONE;
        endcase
    end

    // Next state, cycle bookkeeping and next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        nxt_state = cur_state;
        region_d  = region_q;
        read_d    = read_q;
        wcnt_d    = wcnt_q;
        tcnt_d    = tcnt_q;

        case (cur_state)
            S_IDLE: begin
                if (!as_n) begin
                    nxt_state = S_WAIT;
                    region_d  = decoded;
                    read_d    = read;
                    tcnt_d    = 8'd0;
                    case (decoded)
                        R_ROM:   wcnt_d = 4'(ROM_WAIT);
                        R_RAM:   wcnt_d = 4'(RAM_WAIT);
                        R_IO:    wcnt_d = 4'(IO_WAIT);
                        default: wcnt_d = 4'd0;
                    endcase
                end
            end
            S_WAIT: begin
                if (as_n) begin
                    nxt_state = S_IDLE;
                end else if (wcnt_q == 4'd0 && region_q != R_NONE &&
                             (region_q != R_IO || io_ready)) begin
                    nxt_state = S_ACK;
                end else if (tcnt_q == TMO_LAST) begin
                    nxt_state = S_BERR;
                end else begin
                    if (wcnt_q != 4'd0)
                        wcnt_d = wcnt_q - 4'd1;
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_ACK, S_BERR, S_RECOVER: begin
                if (as_n)
                    nxt_state = S_IDLE;
            end
            default: nxt_state = S_RECOVER;
        endcase

        // Outputs follow the state being entered and the cycle's latched attributes.
        in_cycle      = (nxt_state == S_WAIT) || (nxt_state == S_ACK) || (nxt_state == S_BERR);
        strobes_valid = (nxt_state == S_WAIT) || (nxt_state == S_ACK);

        dtack_d  = (nxt_state != S_ACK);
        berr_d   = (nxt_state != S_BERR);
        rom_cs_d = !(in_cycle && region_d == R_ROM);
        ram_cs_d = !(in_cycle && region_d == R_RAM);
        io_cs_d  = !(in_cycle && region_d == R_IO);
        oe_d     = !(in_cycle && read_d);
        we_hi_d  = strobes_valid ? (ram_cs_d | read_d | uds_n) : 1'b1;
        we_lo_d  = strobes_valid ? (ram_cs_d | read_d | lds_n) : 1'b1;
    end

    // State, counters and registered bus outputs; reset wins even mid-cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            cur_state   <= S_RECOVER;
            region_q    <= R_NONE;
            read_q      <= 1'b1;
            wcnt_q      <= 4'd0;
            tcnt_q      <= 8'd0;
            dtack_n     <= 1'b1;
            berr_n      <= 1'b1;
            rom_cs_n    <= 1'b1;
            ram_cs_n    <= 1'b1;
            io_cs_n     <= 1'b1;
            ram_we_hi_n <= 1'b1;
            ram_we_lo_n <= 1'b1;
            data_oe_n   <= 1'b1;
        end else begin
            cur_state   <= nxt_state;
            region_q    <= region_d;
            read_q      <= read_d;
            wcnt_q      <= wcnt_d;
            tcnt_q      <= tcnt_d;
            dtack_n     <= dtack_d;
            berr_n      <= berr_d;
            rom_cs_n    <= rom_cs_d;
            ram_cs_n    <= ram_cs_d;
            io_cs_n     <= io_cs_d;
            ram_we_hi_n <= we_hi_d;
            ram_we_lo_n <= we_lo_d;
            data_oe_n   <= oe_d;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: each step drives inputs, queues the
// expected post-edge output vector, and compares it one edge later.
module tb_bus_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, as_n, read, uds_n, lds_n, io_ready;
    logic [23:0] addr;
    logic        dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n;
    logic        ram_we_hi_n, ram_we_lo_n, data_oe_n;
    logic [2:0]  state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [10:0] val;
    } exp_t;

    exp_t sb[$];

    // Output vector bit order: state[2:0], dtack, berr, rom, ram, io, we_hi, we_lo, oe.
    localparam logic [7:0] ALL_HI      = 8'b1111_1111;
    localparam logic [7:0] ROM_RD      = 8'b1101_1110;
    localparam logic [7:0] ROM_RD_ACK  = 8'b0101_1110;
    localparam logic [7:0] RAM_WR      = 8'b1110_1011;
    localparam logic [7:0] RAM_WR_ACK  = 8'b0110_1011;
    localparam logic [7:0] RAM_WR_ACK2 = 8'b0110_1001;
    localparam logic [7:0] IO_RD       = 8'b1111_0110;
    localparam logic [7:0] IO_RD_ACK   = 8'b0111_0110;
    localparam logic [7:0] IO_RD_BERR  = 8'b1011_0110;
    localparam logic [7:0] UNM_BERR    = 8'b1011_1111;

    logic [10:0] obs;
    assign obs = {state, dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n,
                  ram_we_hi_n, ram_we_lo_n, data_oe_n};

    bus_cycle_ctrl #(
        .ROM_WAIT(2), .RAM_WAIT(0), .IO_WAIT(3), .BERR_TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset), .as_n(as_n), .read(read),
        .uds_n(uds_n), .lds_n(lds_n), .addr(addr), .io_ready(io_ready),
        .dtack_n(dtack_n), .berr_n(berr_n), .rom_cs_n(rom_cs_n),
        .ram_cs_n(ram_cs_n), .io_cs_n(io_cs_n), .ram_we_hi_n(ram_we_hi_n),
        .ram_we_lo_n(ram_we_lo_n), .data_oe_n(data_oe_n), .state(state)
    );

    always #5 clk = ~clk;

    // Queue the expectation, advance one edge, then compare away from the edge.
    task automatic step(input string tag, input logic [2:0] s, input logic [7:0] o);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.val = {s, o};
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        assert (obs === got.val) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.val);
        end
    endtask

    initial begin
        reset = 1'b1; as_n = 1'b1; read = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        addr = 24'h0; io_ready = 1'b0;

        // Reset held two clocks, then release into IDLE.
        step("reset_0", 3'd4, ALL_HI);
        step("reset_1", 3'd4, ALL_HI);
        reset = 1'b0;
        step("recover_to_idle", 3'd0, ALL_HI);
        step("idle_hold", 3'd0, ALL_HI);

        // ROM read, two wait states: DTACK after edge k+3.
        addr = 24'h000078; read = 1'b1; as_n = 1'b0;
        step("rom_enter", 3'd1, ROM_RD);
        step("rom_wait1", 3'd1, ROM_RD);
        step("rom_wait2", 3'd1, ROM_RD);
        step("rom_ack", 3'd2, ROM_RD_ACK);
        step("rom_ack_hold", 3'd2, ROM_RD_ACK);
        as_n = 1'b1;
        step("rom_release", 3'd0, ALL_HI);

        // RAM write upper byte, zero waits; lower strobe follows live lds_n.
        addr = 24'h100010; read = 1'b0; uds_n = 1'b0; lds_n = 1'b1; as_n = 1'b0;
        step("ram_enter", 3'd1, RAM_WR);
        step("ram_ack", 3'd2, RAM_WR_ACK);
        lds_n = 1'b0;
        step("ram_lds_live", 3'd2, RAM_WR_ACK2);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        step("ram_release", 3'd0, ALL_HI);

        // IO read with io_ready low for 10 clocks after entry, then high.
        addr = 24'hF00004; read = 1'b1; io_ready = 1'b0; as_n = 1'b0;
        step("io_enter", 3'd1, IO_RD);
        for (int i = 0; i < 10; i++)
            step("io_wait_ready", 3'd1, IO_RD);
        io_ready = 1'b1;
        step("io_ack", 3'd2, IO_RD_ACK);
        as_n = 1'b1; io_ready = 1'b0;
        step("io_release", 3'd0, ALL_HI);

        // IO ready arriving on the timeout edge: acknowledge wins.
        as_n = 1'b0;
        step("io_race_enter", 3'd1, IO_RD);
        for (int i = 1; i < 64; i++)
            step("io_race_wait", 3'd1, IO_RD);
        io_ready = 1'b1;
        step("io_race_ack", 3'd2, IO_RD_ACK);
        as_n = 1'b1; io_ready = 1'b0;
        step("io_race_release", 3'd0, ALL_HI);

        // IO with io_ready stuck low: BERR after edge k+64, IO select held.
        as_n = 1'b0;
        step("io_tmo_enter", 3'd1, IO_RD);
        for (int i = 1; i < 64; i++)
            step("io_tmo_wait", 3'd1, IO_RD);
        step("io_tmo_berr", 3'd3, IO_RD_BERR);
        step("io_tmo_hold", 3'd3, IO_RD_BERR);
        as_n = 1'b1;
        step("io_tmo_release", 3'd0, ALL_HI);

        // Unmapped write: no select, BERR after edge k+64.
        addr = 24'h500000; read = 1'b0; as_n = 1'b0;
        step("unm_enter", 3'd1, ALL_HI);
        for (int i = 1; i < 64; i++)
            step("unm_wait", 3'd1, ALL_HI);
        step("unm_berr", 3'd3, UNM_BERR);
        step("unm_hold", 3'd3, UNM_BERR);
        as_n = 1'b1;
        step("unm_release", 3'd0, ALL_HI);

        // Aborted ROM cycle: as_n rises during WAIT, no acknowledge.
        addr = 24'h000100; read = 1'b1; as_n = 1'b0;
        step("abort_enter", 3'd1, ROM_RD);
        as_n = 1'b1;
        step("abort_idle", 3'd0, ALL_HI);
        step("abort_stay", 3'd0, ALL_HI);

        // Back-to-back: a new strobe right after release is accepted next edge.
        as_n = 1'b0;
        step("b2b_enter", 3'd1, ROM_RD);
        step("b2b_wait1", 3'd1, ROM_RD);
        step("b2b_wait2", 3'd1, ROM_RD);
        step("b2b_ack", 3'd2, ROM_RD_ACK);
        as_n = 1'b1;
        step("b2b_release", 3'd0, ALL_HI);
        as_n = 1'b0;
        step("b2b_reenter", 3'd1, ROM_RD);
        as_n = 1'b1;
        step("b2b_abort", 3'd0, ALL_HI);

        // Reset during a ROM WAIT with as_n held low: never acknowledged.
        as_n = 1'b0;
        step("midrst_enter", 3'd1, ROM_RD);
        reset = 1'b1;
        step("midrst_reset", 3'd4, ALL_HI);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)
            step("midrst_recover", 3'd4, ALL_HI);
        as_n = 1'b1;
        step("midrst_idle", 3'd0, ALL_HI);
        as_n = 1'b0;
        step("midrst_new_enter", 3'd1, ROM_RD);
        step("midrst_new_wait1", 3'd1, ROM_RD);
        step("midrst_new_wait2", 3'd1, ROM_RD);
        step("midrst_new_ack", 3'd2, ROM_RD_ACK);
        as_n = 1'b1;
        step("midrst_new_release", 3'd0, ALL_HI);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
